// File: rtl/irt_pkg.sv
// Shared defaults and types for the Instruction Register Table scheduler.
// Empty table slots hold all-ones so that a cleared slot is recognisable.
package irt_pkg;

  localparam int IRT_IW    = 16;
  localparam int IRT_BS    = 16;
  localparam int IRT_REG_W = 4;

  localparam logic [IRT_IW-1:0] IRT_EMPTY = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } irt_state_e;

endpackage

// File: rtl/irt_hazard_cmp.sv
// Combinational RAW check: does the next source tag match the destination tag
// of any entry inside the issued-but-unretired window?
module irt_hazard_cmp
  import irt_pkg::*;
#(
  parameter int BS    = IRT_BS,
  parameter int REG_W = IRT_REG_W
) (
  input  logic [REG_W-1:0]         rs,
  input  logic [BS-1:0][REG_W-1:0] rd_tags,
  input  logic [BS-1:0]            mask,
  output logic                     hazard
);

  // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < BS; i++) begin
      if (mask[i] && (rd_tags[i] == rs)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/irt_sched.sv
// In-order IRT scheduler: circular table with alloc/issue/retire pointers,
// RAW stall against issued entries, and a one-slot-per-cycle clear walk.
module irt_sched
  import irt_pkg::*;
#(
  parameter int IW     = IRT_IW,
  parameter int BS     = IRT_BS,
  parameter int REG_W  = IRT_REG_W,
  parameter int RD_LSB = 8,
  parameter int RS_LSB = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_instr,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [IW-1:0]         issue_instr,
  output logic [$clog2(BS)-1:0] issue_idx,
  input  logic                  retire_valid,
  input  logic                  flush,
  output logic                  busy,
  output logic                  err_retire
);

  localparam int IDX_W = $clog2(BS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BS - 1);

  irt_state_e               state;
  logic [IDX_W-1:0]         tail, iptr, rptr, clr_idx;
  logic [CNT_W-1:0]         cnt, icnt;   // icnt: entries issued but not retired
  logic [IW-1:0]            instr_mem [BS];
  logic [BS-1:0][REG_W-1:0] rd_tag, rs_tag;
  logic [BS-1:0]            valid, issued_mask;
  logic                     hazard, accept, issue, retire, retire_err;

  assign busy        = (state == CLEAR);
  assign in_ready    = (state == RUN) && (cnt != FULL);
  assign issue_valid = (state == RUN) && (cnt != icnt) && !hazard;
  assign issue_instr = instr_mem[iptr];
  assign issue_idx   = iptr;

  assign accept     = in_valid && in_ready;
  assign issue      = issue_valid && issue_ready;
  assign retire     = (state == RUN) && retire_valid && (icnt != '0);
  assign retire_err = (state == RUN) && retire_valid && (icnt == '0);

  // Slot g is in the issued window when its distance from rptr is below icnt.
  for (genvar g = 0; g < BS; g++) begin : g_mask
    logic [IDX_W-1:0] off;
    assign off            = IDX_W'(g) - rptr;
    assign issued_mask[g] = valid[g] && ({1'b0, off} < icnt);
  end

  irt_hazard_cmp #(.BS(BS), .REG_W(REG_W)) u_hazard (
    .rs      (rs_tag[iptr]),
    .rd_tags (rd_tag),
    .mask    (issued_mask),
    .hazard  (hazard)
  );

  // NOTE: table storage is not reset directly; the CLEAR walk rewrites one slot per cycle instead.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= CLEAR;
      tail       <= '0;
      iptr       <= '0;
      rptr       <= '0;
      clr_idx    <= '0;
      cnt        <= '0;
      icnt       <= '0;
      err_retire <= 1'b0;
    end else begin
      err_retire <= retire_err;
      case (state)
        CLEAR: begin
          instr_mem[clr_idx] <= '1;
          rd_tag[clr_idx]    <= '1;
          rs_tag[clr_idx]    <= '1;
          valid[clr_idx]     <= 1'b0;
          clr_idx            <= clr_idx + 1'b1;
          if (clr_idx == LAST) state <= RUN;
        end
        RUN: begin
          // tail never equals rptr while both accept and retire fire, so slots do not collide.
          if (accept) begin
            instr_mem[tail] <= in_instr;
            rd_tag[tail]    <= in_instr[RD_LSB +: REG_W];
            rs_tag[tail]    <= in_instr[RS_LSB +: REG_W];
            valid[tail]     <= 1'b1;
            tail            <= tail + 1'b1;
          end
          if (issue) iptr <= iptr + 1'b1;
          if (retire) begin
            instr_mem[rptr] <= '1;
            rd_tag[rptr]    <= '1;
            rs_tag[rptr]    <= '1;
            valid[rptr]     <= 1'b0;
            rptr            <= rptr + 1'b1;
          end
          cnt  <= cnt  + CNT_W'(accept) - CNT_W'(retire);
          icnt <= icnt + CNT_W'(issue)  - CNT_W'(retire);
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_irt_sched.sv
// Directed bench for irt_sched: a vector table for stream/stall/error cases,
// plus hand-written flush and full/wrap sequences.
module tb_irt_sched;
  import irt_pkg::*;

  localparam int IDX_W = $clog2(IRT_BS);

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, issue_valid, issue_ready;
  logic             retire_valid, flush, busy, err_retire;
  logic [15:0]      in_instr, issue_instr;
  logic [IDX_W-1:0] issue_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irt_sched dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_idx    (issue_idx),
    .retire_valid (retire_valid),
    .flush        (flush),
    .busy         (busy),
    .err_retire   (err_retire)
  );

  typedef struct {
    logic             iv;
    logic [15:0]      instr;
    logic             ir;
    logic             rv;
    logic             e_rdy;
    logic             e_iv;
    logic [IDX_W-1:0] e_idx;
    logic [15:0]      e_instr;
    logic             e_err;
    int               e_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (busy && n < 64) begin
      n++;
      cyc();
    end
    check(name, n, 16);
  endtask

  function automatic vec_t mk(input logic iv, input logic [15:0] instr, input logic ir,
                              input logic rv, input logic e_rdy, input logic e_iv,
                              input logic [IDX_W-1:0] e_idx, input logic [15:0] e_instr,
                              input logic e_err, input int e_cnt);
    vec_t v;
    v.iv = iv; v.instr = instr; v.ir = ir; v.rv = rv;
    v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_idx = e_idx;
    v.e_instr = e_instr; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int   found;
    // Expected outputs describe the state before the row's inputs take effect.
    //            iv  instr     ir  rv | rdy iv  idx  instr     err cnt
    vecs[0]  = mk(1, 16'h0120, 1, 0,   1,  0,  0, 16'hFFFF, 0,  0);  // independent stream
    vecs[1]  = mk(1, 16'h0340, 1, 0,   1,  1,  0, 16'h0120, 0,  1);
    vecs[2]  = mk(0, 16'h0000, 1, 0,   1,  1,  1, 16'h0340, 0,  2);
    vecs[3]  = mk(0, 16'h0000, 0, 1,   1,  0,  2, 16'hFFFF, 0,  2);
    vecs[4]  = mk(0, 16'h0000, 0, 1,   1,  0,  2, 16'hFFFF, 0,  1);
    vecs[5]  = mk(1, 16'h0120, 1, 0,   1,  0,  2, 16'hFFFF, 0,  0);  // RAW stall
    vecs[6]  = mk(1, 16'h0510, 1, 0,   1,  1,  2, 16'h0120, 0,  1);
    vecs[7]  = mk(0, 16'h0000, 1, 0,   1,  0,  3, 16'h0510, 0,  2);
    vecs[8]  = mk(0, 16'h0000, 1, 0,   1,  0,  3, 16'h0510, 0,  2);
    vecs[9]  = mk(0, 16'h0000, 1, 1,   1,  0,  3, 16'h0510, 0,  2);
    vecs[10] = mk(0, 16'h0000, 1, 0,   1,  1,  3, 16'h0510, 0,  1);
    vecs[11] = mk(0, 16'h0000, 0, 1,   1,  0,  4, 16'hFFFF, 0,  1);
    vecs[12] = mk(0, 16'h0000, 0, 1,   1,  0,  4, 16'hFFFF, 0,  0);  // retire with none issued
    vecs[13] = mk(1, 16'h0760, 1, 0,   1,  0,  4, 16'hFFFF, 1,  0);
    vecs[14] = mk(1, 16'h0890, 1, 0,   1,  1,  4, 16'h0760, 0,  1);
    vecs[15] = mk(1, 16'h0AB0, 1, 1,   1,  1,  5, 16'h0890, 0,  2);  // accept+issue+retire
    vecs[16] = mk(0, 16'h0000, 0, 0,   1,  1,  6, 16'h0AB0, 0,  2);
    vecs[17] = mk(0, 16'h0000, 1, 1,   1,  1,  6, 16'h0AB0, 0,  2);
    vecs[18] = mk(0, 16'h0000, 0, 1,   1,  0,  7, 16'hFFFF, 0,  1);
    vecs[19] = mk(0, 16'h0000, 0, 0,   1,  0,  7, 16'hFFFF, 0,  0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    issue_ready = 1'b0; retire_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    check("rst_busy", busy, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_err_retire", err_retire, 0);
    wait_clear("rst_busy_cycles");
    check("clr_in_ready", in_ready, 1);
    check("clr_issue_valid", issue_valid, 0);
    check("clr_slot0", issue_instr, IRT_EMPTY);

    for (int k = 0; k < 20; k++) begin
      check($sformatf("v%0d_in_ready", k), in_ready, vecs[k].e_rdy);
      check($sformatf("v%0d_issue_valid", k), issue_valid, vecs[k].e_iv);
      check($sformatf("v%0d_issue_idx", k), issue_idx, vecs[k].e_idx);
      check($sformatf("v%0d_issue_instr", k), issue_instr, vecs[k].e_instr);
      check($sformatf("v%0d_err_retire", k), err_retire, vecs[k].e_err);
      check($sformatf("v%0d_cnt", k), 32'(dut.cnt), vecs[k].e_cnt);
      in_valid = vecs[k].iv; in_instr = vecs[k].instr;
      issue_ready = vecs[k].ir; retire_valid = vecs[k].rv;
      cyc();
    end
    in_valid = 1'b0; issue_ready = 1'b0; retire_valid = 1'b0;

    // Flush with 5 pending and 2 issued; same-cycle accept/issue must be dropped.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = {4'h0, 4'(i), 4'(i + 8), 4'h0};
      issue_ready = (i == 1) || (i == 2);
      cyc();
    end
    in_valid = 1'b0; issue_ready = 1'b0;
    check("pre_flush_cnt", 32'(dut.cnt), 7);
    check("pre_flush_issue_idx", issue_idx, 9);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h0BC0; issue_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_in_ready", in_ready, 0);
    check("flush_issue_valid", issue_valid, 0);
    wait_clear("flush_busy_cycles");
    check("post_flush_cnt", 32'(dut.cnt), 0);
    check("post_flush_issue_valid", issue_valid, 0);
    check("post_flush_in_ready", in_ready, 1);
    check("post_flush_issue_idx", issue_idx, 0);

    // Fill to 16 entries; slot i holds rd=i, rs=i+8 so neighbours never collide.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill%0d_in_ready", i), in_ready, 1);
      in_valid = 1'b1;
      in_instr = {4'h0, 4'(i), 4'(i + 8), 4'h0};
      cyc();
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_cnt", 32'(dut.cnt), 16);
    check("full_issue_valid", issue_valid, 1);
    check("full_issue_idx", issue_idx, 0);
    in_valid = 1'b1; in_instr = 16'hFACE; issue_ready = 1'b1;
    cyc();
    issue_ready = 1'b0;
    check("full_issued_in_ready", in_ready, 0);
    retire_valid = 1'b1;
    check("full_retire_in_ready", in_ready, 0);
    cyc();
    retire_valid = 1'b0;
    check("after_retire_in_ready", in_ready, 1);
    check("after_retire_cnt", 32'(dut.cnt), 15);
    in_instr = 16'h0ED0;
    cyc();
    in_valid = 1'b0;
    check("refill_in_ready", in_ready, 0);
    check("refill_cnt", 32'(dut.cnt), 16);

    // Drain in order until the wrapped entry reaches slot 0.
    found = 0;
    for (int j = 0; j < 40; j++) begin
      if (issue_valid && issue_idx == '0) begin
        found = 1;
        break;
      end
      issue_ready = 1'b1;
      retire_valid = (j > 0);
      cyc();
    end
    issue_ready = 1'b0; retire_valid = 1'b0;
    check("wrap_slot0_found", found, 1);
    check("wrap_slot0_instr", issue_instr, 16'h0ED0);
    check("drain_err_retire", err_retire, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
